// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback buffer.
package wb_pkg;

   localparam int unsigned WB_LANES  = 5;
   localparam int unsigned WB_WPORTS = 2;
   localparam int unsigned WB_DEPTH  = 8;
   localparam int unsigned WB_DST_W  = 5;
   localparam int unsigned WB_DATA_W = 64;

   typedef struct packed {
      logic [WB_DST_W-1:0]  dst;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/lane_compactor.sv
// Packs the valid, non-x0 commit lanes into consecutive slots in ascending lane order.
module lane_compactor
   import wb_pkg::*;
#(
   parameter int unsigned LANES  = WB_LANES,
   parameter int unsigned DST_W  = WB_DST_W,
   parameter int unsigned DATA_W = WB_DATA_W,
   parameter int unsigned CNT_W  = $clog2(WB_LANES + 1)
) (
   input  logic [LANES-1:0]        in_valid_i,
   input  logic [LANES*DST_W-1:0]  in_dst_i,
   input  logic [LANES*DATA_W-1:0] in_data_i,
   output wb_entry_t [LANES-1:0]   entries_o,
   output logic [CNT_W-1:0]        enq_cnt_o
);

   logic [CNT_W-1:0] pos;

   // pos is the running prefix count of kept lanes below lane i
   always_comb begin
      entries_o = '0;
      pos       = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_valid_i[i] && (in_dst_i[i*DST_W +: DST_W] != '0)) begin
            entries_o[pos].dst  = in_dst_i[i*DST_W +: DST_W];
            entries_o[pos].data = in_data_i[i*DATA_W +: DATA_W];
            pos = pos + CNT_W'(1);
         end
      end
      enq_cnt_o = pos;
   end

endmodule

// File: rtl/writeback_buffer.sv
// Commit-bundle FIFO draining up to WPORTS results per cycle into the register file.
// Optional same-cycle bypass into an empty FIFO is enabled by defining WB_BYPASS_EN.
module writeback_buffer
   import wb_pkg::*;
#(
   parameter int unsigned LANES  = WB_LANES,
   parameter int unsigned WPORTS = WB_WPORTS,
   parameter int unsigned DEPTH  = WB_DEPTH,
   parameter int unsigned DST_W  = WB_DST_W,
   parameter int unsigned DATA_W = WB_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*DST_W-1:0]     in_dst,
   input  logic [LANES*DATA_W-1:0]    in_data,
   output logic                       stall,
   output logic [WPORTS-1:0]          wr_en,
   output logic [WPORTS*DST_W-1:0]    wr_addr,
   output logic [WPORTS*DATA_W-1:0]   wr_data,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = $clog2(DEPTH) + 1;
   localparam int unsigned CntW = $clog2(LANES + 1);

   wb_entry_t [LANES-1:0] cmp_entries;
   logic [CntW-1:0]       cmp_cnt;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [OccW-1:0]       occ_q, occ_d;
   logic [OccW-1:0]       deq_n;
   logic [CntW-1:0]       enq_n;
   logic [CntW-1:0]       skip;
   logic                  accept;
   wb_entry_t             mem_q [DEPTH];

   lane_compactor #(
      .LANES  (LANES),
      .DST_W  (DST_W),
      .DATA_W (DATA_W),
      .CNT_W  (CntW)
   ) u_compactor (
      .in_valid_i (in_valid),
      .in_dst_i   (in_dst),
      .in_data_i  (in_data),
      .entries_o  (cmp_entries),
      .enq_cnt_o  (cmp_cnt)
   );

   assign stall     = (int'(DEPTH) - int'(occ_q)) < int'(LANES);
   assign accept    = !stall && !flush;
   assign occupancy = occ_q;

`ifdef WB_BYPASS_EN
   logic byp_act;
   assign byp_act = !reset && accept && (occ_q == '0);
`endif

   // skip counts compacted inputs sent straight to the ports instead of the FIFO
   always_comb begin
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      deq_n   = '0;
      skip    = '0;
`ifdef WB_BYPASS_EN
      if (byp_act) begin
         for (int i = 0; i < WPORTS; i++) begin
            if (i < int'(cmp_cnt)) begin
               wr_en[i]                    = 1'b1;
               wr_addr[i*DST_W +: DST_W]   = cmp_entries[i].dst;
               wr_data[i*DATA_W +: DATA_W] = cmp_entries[i].data;
               skip = skip + CntW'(1);
            end
         end
      end else
`endif
      if (!flush) begin
         for (int i = 0; i < WPORTS; i++) begin
            if (i < int'(occ_q)) begin
               wr_en[i]                    = 1'b1;
               wr_addr[i*DST_W +: DST_W]   = mem_q[PtrW'(rd_ptr_q + PtrW'(i))].dst;
               wr_data[i*DATA_W +: DATA_W] = mem_q[PtrW'(rd_ptr_q + PtrW'(i))].data;
               deq_n = deq_n + OccW'(1);
            end
         end
      end
   end

   assign enq_n = accept ? (cmp_cnt - skip) : '0;

   always_comb begin
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PtrW'(deq_n);
         wr_ptr_d = wr_ptr_q + PtrW'(enq_n);
         occ_d    = occ_q + OccW'(enq_n) - deq_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < LANES; k++) begin
            if (k < int'(enq_n)) begin
               mem_q[PtrW'(wr_ptr_q + PtrW'(k))] <= cmp_entries[k + int'(skip)];
            end
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         assert (int'(enq_n) <= int'(DEPTH) - int'(occ_q) + int'(deq_n))
         else $error("writeback_buffer: enqueue overruns free space");
      end
   end
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomised scoreboard bench for writeback_buffer against a queue-based reference model.
module tb_writeback_buffer;

   localparam int LANES  = 5;
   localparam int WPORTS = 2;
   localparam int DEPTH  = 8;

   typedef struct packed {
      logic [4:0]  dst;
      logic [63:0] data;
   } res_t;

   typedef struct {
      logic             stall;
      int               occ;
      int               nwr;
      logic [1:0][4:0]  a;
      logic [1:0][63:0] d;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic [4:0]   in_valid = '0;
   logic [24:0]  in_dst = '0;
   logic [319:0] in_data = '0;
   logic         stall;
   logic [1:0]   wr_en;
   logic [9:0]   wr_addr;
   logic [127:0] wr_data;
   logic [3:0]   occupancy;

   writeback_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_dst    (in_dst),
      .in_data   (in_data),
      .stall     (stall),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc_res = 0;
   res_t m[$];
   exp_t exp_q[$];
   exp_t mon_e;

   logic [4:0]   s_v;
   logic [24:0]  s_d;
   logic [319:0] s_x;
   logic [63:0]  seq = 64'h1000;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, req, $time);
      end
   endfunction

   // Reference: a FIFO of results; each cycle retire up to WPORTS oldest, then append accepted ones.
   task automatic model_cycle();
      exp_t e;
      res_t comp[$];
      res_t r;
      bit   acc;
      e.stall = 1'b0;
      e.occ   = 0;
      e.nwr   = 0;
      e.a     = '0;
      e.d     = '0;
      if (reset) begin
         m.delete();
      end else begin
         e.stall = (DEPTH - m.size()) < LANES;
         e.occ   = m.size();
         acc     = !e.stall && !flush;
         for (int i = 0; i < LANES; i++)
            if (in_valid[i] && in_dst[i*5 +: 5] != 5'd0)
               comp.push_back('{dst: in_dst[i*5 +: 5], data: in_data[i*64 +: 64]});
         if (!flush) begin
`ifdef WB_BYPASS_EN
            if (m.size() == 0 && acc) begin
               while (e.nwr < WPORTS && comp.size() > 0) begin
                  r = comp.pop_front();
                  e.a[e.nwr] = r.dst;
                  e.d[e.nwr] = r.data;
                  e.nwr++;
                  acc_res++;
               end
            end else
`endif
            while (e.nwr < WPORTS && m.size() > 0) begin
               r = m.pop_front();
               e.a[e.nwr] = r.dst;
               e.d[e.nwr] = r.data;
               e.nwr++;
            end
         end
         if (flush) m.delete();
         else if (acc) begin
            foreach (comp[k]) m.push_back(comp[k]);
            acc_res += comp.size();
         end
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("stall", {63'd0, stall}, {63'd0, mon_e.stall});
         chk("occupancy", {60'd0, occupancy}, 64'(mon_e.occ));
         chk("wr_en", {62'd0, wr_en}, 64'((1 << mon_e.nwr) - 1));
         for (int p = 0; p < WPORTS; p++) begin
            if (p < mon_e.nwr) begin
               chk($sformatf("wr_addr%0d", p), {59'd0, wr_addr[p*5 +: 5]}, {59'd0, mon_e.a[p]});
               chk($sformatf("wr_data%0d", p), wr_data[p*64 +: 64], mon_e.d[p]);
            end
         end
      end
   end

   task automatic clr();
      s_v = '0;
      s_d = '0;
      s_x = '0;
   endtask

   task automatic put(input int i, input logic [4:0] dst, input logic [63:0] x);
      s_v[i]         = 1'b1;
      s_d[i*5 +: 5]  = dst;
      s_x[i*64 +: 64] = x;
   endtask

   task automatic go(input logic f, input logic r);
      @(posedge clk);
      #1;
      reset    = r;
      flush    = f;
      in_valid = s_v;
      in_dst   = s_d;
      in_data  = s_x;
      model_cycle();
   endtask

   task automatic full_bundle();
      clr();
      for (int l = 0; l < LANES; l++) begin
         put(l, 5'($urandom_range(1, 31)), seq);
         seq++;
      end
   endtask

   task automatic idle(input int n);
      clr();
      for (int k = 0; k < n; k++) go(1'b0, 1'b0);
   endtask

   initial begin
      int start;
      clr();
      go(1'b0, 1'b1);
      go(1'b0, 1'b1);

      // compaction: lanes 0,2,4 valid
      clr();
      put(0, 5'd1, 64'h11);
      put(2, 5'd3, 64'h33);
      put(4, 5'd4, 64'h44);
      s_d[1*5 +: 5] = 5'd0;
      go(1'b0, 1'b0);
      idle(3);

      // x0 drop: lanes 1 and 3 target x0
      clr();
      put(0, 5'd7, 64'hA0);
      put(1, 5'd0, 64'hA1);
      put(2, 5'd8, 64'hA2);
      put(3, 5'd0, 64'hA3);
      put(4, 5'd9, 64'hA4);
      go(1'b0, 1'b0);
      idle(3);

      // back-pressure and pointer wrap over a 40-result stream
      start = acc_res;
      for (int k = 0; k < 40 && (acc_res - start) < 40; k++) begin
         full_bundle();
         go(1'b0, 1'b0);
      end
      idle(25);

      // reset with traffic in flight
      full_bundle();
      go(1'b0, 1'b0);
      full_bundle();
      go(1'b0, 1'b1);
      go(1'b1, 1'b1);
      idle(4);

      // flush with occupancy 6 and a full incoming bundle
      for (int k = 0; k < 10 && m.size() != 6; k++) begin
         full_bundle();
         go(1'b0, 1'b0);
      end
      full_bundle();
      go(1'b1, 1'b0);
      idle(4);

      // empty-FIFO burst followed immediately by another while one result remains
      clr();
      put(0, 5'd2, 64'hB0);
      put(1, 5'd3, 64'hB1);
      put(3, 5'd4, 64'hB3);
      go(1'b0, 1'b0);
      clr();
      put(1, 5'd5, 64'hC1);
      put(2, 5'd6, 64'hC2);
      put(4, 5'd7, 64'hC4);
      go(1'b0, 1'b0);
      idle(4);

      // random traffic
      for (int k = 0; k < 300; k++) begin
         clr();
         for (int l = 0; l < LANES; l++) begin
            if ($urandom_range(0, 3) != 0) begin
               put(l, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   {$urandom, $urandom});
            end
         end
         go(($urandom_range(0, 29) == 0), 1'b0);
      end
      idle(10);

      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
